// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks.
// UART_TX_PARITY_EN selects the 11-bit frame with even parity.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_BITS = 11;
`else
  localparam int UART_FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer shared by the UART transmitter and receiver.
// bit_end_o is high in the last cycle of each CLKS_PER_BIT-long period.
module baud_counter #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic reload_i,
  output logic bit_end_o
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || reload_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign bit_end_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first; UART_TX_PARITY_EN adds an even-parity bit.
// Handshake: a start is taken in IDLE when tx_start_i=1 and the line was seen low since the last acceptance.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [7:0]     tx_data_i,
  input  logic           tx_start_i,
  output logic           tx_done_o,
  output logic           tx_busy_o,
  output logic           tx_o,
  output uart_tx_state_e state_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
  endgenerate

  uart_tx_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       armed_q;
  logic       tx_d, busy_d, done_d;
  logic       accept, bit_end, reload;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .reload_i  (reload),
    .bit_end_o (bit_end)
  );

  assign accept = (state_q == ST_IDLE) && tx_start_i && armed_q;
  // Every state change happens at bit_end or acceptance, so reloading there keeps bits drift-free.
  assign reload = accept || (bit_end && (state_q != ST_IDLE));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = accept ? ^tx_data_i : parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START;
          shift_d   = tx_data_i;
          bit_cnt_d = '0;
        end
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP: if (bit_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Line level is computed from the next state so tx_o can be a plain register.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && bit_end;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      armed_q   <= 1'b1;
      tx_o      <= 1'b1;
      tx_busy_o <= 1'b0;
      tx_done_o <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      if (accept)          armed_q <= 1'b0;
      else if (!tx_start_i) armed_q <= 1'b1;
      tx_o      <= tx_d;
      tx_busy_o <= busy_d;
      tx_done_o <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign state_o = state_q;

endmodule
